// File: rtl/ram_simple_dp_sc_param.sv
// Single-clock simple dual-port RAM with byte enables, a post-reset clear sweep and a
// selectable read-during-write policy. Define RAM_SDP_OUTREG_EN for a second output register.
module ram_simple_dp_sc_param #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 512,
  parameter int RDW_MODE   = 0
) (
  input  logic                             clock,
  input  logic                             reset_n,
  output logic                             init_busy,
  input  logic                             we,
  input  logic [ADDR_WIDTH-1:0]            write_addr,
  input  logic [DATA_WIDTH-1:0]            din,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byte_en,
  input  logic                             re,
  input  logic [ADDR_WIDTH-1:0]            read_addr,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic                             dout_valid
);

  localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   clear_addr;
  logic [ADDR_WIDTH-1:0]   clear_addr_next;

  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];
  logic [IDX_WIDTH-1:0]    write_idx;
  logic [IDX_WIDTH-1:0]    read_idx;
  logic [IDX_WIDTH-1:0]    clear_idx;
  logic                    write_ok;
  logic                    read_ok;
  logic                    read_in_range;
  logic [DATA_WIDTH-1:0]   read_word;
  logic [DATA_WIDTH-1:0]   dout_q;
  logic                    valid_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_INIT;
      clear_addr <= '0;
    end else begin
      state      <= state_next;
      clear_addr <= clear_addr_next;
    end
  end

  always_comb begin
    state_next      = state;
    clear_addr_next = clear_addr;
    init_busy       = 1'b0;
    case (state)
      ST_INIT: begin
        init_busy = 1'b1;
        if (clear_addr == LAST_ADDR) begin
          state_next = ST_READY;
        end else begin
          clear_addr_next = clear_addr + ADDR_WIDTH'(1);
        end
      end
      ST_READY: begin
        state_next = ST_READY;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  assign write_idx     = write_addr[IDX_WIDTH-1:0];
  assign read_idx      = read_addr[IDX_WIDTH-1:0];
  assign clear_idx     = clear_addr[IDX_WIDTH-1:0];
  assign read_in_range = ({1'b0, read_addr} < DEPTH_EXT);
  assign write_ok      = (state == ST_READY) && we && ({1'b0, write_addr} < DEPTH_EXT);
  assign read_ok       = (state == ST_READY) && re;

  // Storage has no reset; the INIT sweep owns the write port until every word is zero.
  always_ff @(posedge clock) begin
    if (state == ST_INIT) begin
      mem[clear_idx] <= '0;
    end else if (write_ok) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (byte_en[i]) begin
          mem[write_idx][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // A same-address write only shows up here in forwarding mode; otherwise the old word is read.
  always_comb begin
    read_word = '0;
    if (read_in_range) begin
      read_word = mem[read_idx];
    end
    if ((RDW_MODE == 1) && write_ok && (write_addr == read_addr)) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (byte_en[i]) begin
          read_word[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= read_ok;
      if (read_ok) begin
        dout_q <= read_word;
      end
    end
  end

`ifdef RAM_SDP_OUTREG_EN
  logic [DATA_WIDTH-1:0] dout_q2;
  logic                  valid_q2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dout_q2  <= '0;
      valid_q2 <= 1'b0;
    end else begin
      dout_q2  <= dout_q;
      valid_q2 <= valid_q;
    end
  end

  assign dout       = dout_q2;
  assign dout_valid = valid_q2;
`else
  assign dout       = dout_q;
  assign dout_valid = valid_q;
`endif

endmodule

// File: tb/tb_ram_simple_dp_sc_param.sv
// Bench for ram_simple_dp_sc_param: two instances (512 words old-data, 300 words forwarding)
// share stimulus and are compared every cycle against an array-based reference model.
module tb_ram_simple_dp_sc_param;

`ifdef RAM_SDP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH_A = 512;
  localparam int DEPTH_B = 300;

  typedef struct {
    logic        w;
    logic [8:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        r;
    logic [8:0]  ra;
  } op_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [8:0]  write_addr = '0;
  logic [8:0]  read_addr = '0;
  logic [31:0] din = '0;
  logic [3:0]  byte_en = '0;
  logic        busyA, busyB, validA, validB;
  logic [31:0] doutA, doutB;

  logic [31:0] doutW [2];
  logic        validW [2];
  logic        busyW [2];

  int          total = 0;
  int          bad = 0;
  int          depthOf [2] = '{DEPTH_A, DEPTH_B};
  bit          newOnRdw [2] = '{1'b0, 1'b1};
  logic [31:0] modelMem [2][512];
  int          busyLeft [2];
  logic [31:0] s1D [2];
  logic [31:0] expD [2];
  logic        s1V [2];
  logic        expV [2];

  always #5 clock = ~clock;

  ram_simple_dp_sc_param #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(9),
                           .DEPTH(DEPTH_A), .RDW_MODE(0)) dutA (
    .clock(clock), .reset_n(reset_n), .init_busy(busyA), .we(we), .write_addr(write_addr),
    .din(din), .byte_en(byte_en), .re(re), .read_addr(read_addr), .dout(doutA),
    .dout_valid(validA));

  ram_simple_dp_sc_param #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(9),
                           .DEPTH(DEPTH_B), .RDW_MODE(1)) dutB (
    .clock(clock), .reset_n(reset_n), .init_busy(busyB), .we(we), .write_addr(write_addr),
    .din(din), .byte_en(byte_en), .re(re), .read_addr(read_addr), .dout(doutB),
    .dout_valid(validB));

  assign doutW[0] = doutA;
  assign doutW[1] = doutB;
  assign validW[0] = validA;
  assign validW[1] = validB;
  assign busyW[0] = busyA;
  assign busyW[1] = busyB;

  function automatic logic [31:0] merge(input logic [31:0] oldW, input logic [31:0] newW,
                                        input logic [3:0] be);
    logic [31:0] res;
    res = oldW;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[i*8 +: 8] = newW[i*8 +: 8];
    end
    return res;
  endfunction

  function automatic op_t mk_op(input logic w, input logic [8:0] wa, input logic [31:0] wd,
                                input logic [3:0] be, input logic r, input logic [8:0] ra);
    op_t o;
    o.w = w; o.wa = wa; o.wd = wd; o.be = be; o.r = r; o.ra = ra;
    return o;
  endfunction

  function automatic op_t mk_idle();
    return mk_op(1'b0, 9'd0, 32'h0, 4'h0, 1'b0, 9'd0);
  endfunction

  function automatic op_t mk_random(input bit narrow);
    op_t o;
    o.w  = 1'($urandom_range(0, 1));
    o.r  = 1'($urandom_range(0, 1));
    o.wa = narrow ? 9'($urandom_range(0, 15)) : 9'($urandom_range(0, 511));
    o.ra = narrow ? 9'($urandom_range(0, 15)) : 9'($urandom_range(0, 511));
    o.wd = $urandom();
    o.be = 4'($urandom_range(0, 15));
    return o;
  endfunction

  function automatic logic [31:0] bb_data(input int j);
    return 32'hB0B00000 + 32'(j) * 32'h00010203;
  endfunction

  task automatic apply_op(input op_t o);
    we = o.w; write_addr = o.wa; din = o.wd; byte_en = o.be; re = o.r; read_addr = o.ra;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      busyLeft[k] = depthOf[k];
      s1D[k] = '0; s1V[k] = 1'b0; expD[k] = '0; expV[k] = 1'b0;
      for (int a = 0; a < 512; a++) modelMem[k][a] = '0;
    end
  endtask

  // Advance one clock edge and update the reference model from the inputs it sampled.
  task automatic step();
    logic [31:0] nD;
    logic        nV;
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      nD = s1D[k];
      nV = 1'b0;
      if (busyLeft[k] > 0) begin
        busyLeft[k]--;
      end else begin
        if (re) begin
          nV = 1'b1;
          if (int'(read_addr) < depthOf[k]) begin
            nD = modelMem[k][read_addr];
            if (newOnRdw[k] && we && write_addr == read_addr) nD = merge(nD, din, byte_en);
          end else begin
            nD = '0;
          end
        end
        if (we && int'(write_addr) < depthOf[k])
          modelMem[k][write_addr] = merge(modelMem[k][write_addr], din, byte_en);
      end
      if (LAT == 2) begin
        expD[k] = s1D[k]; expV[k] = s1V[k];
      end else begin
        expD[k] = nD; expV[k] = nV;
      end
      s1D[k] = nD;
      s1V[k] = nV;
    end
    #1;
  endtask

  task automatic test_reset();
    int  highCnt [2];
    op_t ops [$];
    reset_n = 1'b0;
    apply_op(mk_idle());
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({busyW[k], validW[k], doutW[k]} !== {1'b1, 1'b0, 32'h0}) begin
        bad++;
        $display("[TB] FAIL reset_values dut%0d got busy/valid/dout=%b/%b/%h want 1/0/00000000",
                 k, busyW[k], validW[k], doutW[k]);
      end
    end
    reset_n = 1'b1;
    for (int k = 0; k < 2; k++) highCnt[k] = int'(busyW[k]);
    for (int c = 0; c < DEPTH_A + 4; c++) begin
      apply_op((c < DEPTH_B) ? mk_random(1'b0) : mk_idle());
      step();
      for (int k = 0; k < 2; k++) begin
        highCnt[k] += int'(busyW[k]);
        total++;
        if ({busyW[k], validW[k], doutW[k]} !== {busyLeft[k] > 0, expV[k], expD[k]}) begin
          bad++;
          $display("[TB] FAIL init_sweep dut%0d cycle %0d got %b/%b/%h want %b/%b/%h", k, c,
                   busyW[k], validW[k], doutW[k], busyLeft[k] > 0, expV[k], expD[k]);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      total++;
      if (highCnt[k] != depthOf[k]) begin
        bad++;
        $display("[TB] FAIL busy_cycles dut%0d got %0d want %0d", k, highCnt[k], depthOf[k]);
      end
    end
    ops.push_back(mk_op(1'b0, 9'd0, 32'h0, 4'h0, 1'b1, 9'd0));
    ops.push_back(mk_op(1'b0, 9'd0, 32'h0, 4'h0, 1'b1, 9'd255));
    ops.push_back(mk_op(1'b0, 9'd0, 32'h0, 4'h0, 1'b1, 9'd511));
    for (int i = 0; i < LAT; i++) ops.push_back(mk_idle());
    for (int i = 0; i < ops.size(); i++) begin
      apply_op(ops[i]);
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({busyW[k], validW[k], doutW[k]} !== {busyLeft[k] > 0, expV[k], expD[k]}) begin
          bad++;
          $display("[TB] FAIL post_init_read dut%0d step %0d got %b/%b/%h want %b/%b/%h", k, i,
                   busyW[k], validW[k], doutW[k], busyLeft[k] > 0, expV[k], expD[k]);
        end
        if (i >= LAT - 1 && i < LAT + 2) begin
          total++;
          if ({validW[k], doutW[k]} !== {1'b1, 32'h0}) begin
            bad++;
            $display("[TB] FAIL post_init_zero dut%0d step %0d got %b/%h want 1/00000000",
                     k, i, validW[k], doutW[k]);
          end
        end
      end
    end
  endtask

  task automatic test_byte_enable();
    op_t ops [$];
    ops.push_back(mk_op(1'b1, 9'd5, 32'hDEADBEEF, 4'b1111, 1'b0, 9'd0));
    ops.push_back(mk_op(1'b1, 9'd5, 32'h11223344, 4'b0101, 1'b0, 9'd0));
    ops.push_back(mk_op(1'b0, 9'd0, 32'h0, 4'h0, 1'b1, 9'd5));
    for (int i = 0; i < LAT; i++) ops.push_back(mk_idle());
    for (int i = 0; i < ops.size(); i++) begin
      apply_op(ops[i]);
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({busyW[k], validW[k], doutW[k]} !== {busyLeft[k] > 0, expV[k], expD[k]}) begin
          bad++;
          $display("[TB] FAIL byte_en_model dut%0d step %0d got %b/%b/%h want %b/%b/%h", k, i,
                   busyW[k], validW[k], doutW[k], busyLeft[k] > 0, expV[k], expD[k]);
        end
        if (i == LAT + 1) begin
          total++;
          if ({validW[k], doutW[k]} !== {1'b1, 32'hDE22BE44}) begin
            bad++;
            $display("[TB] FAIL byte_en_merge dut%0d got %b/%h want 1/de22be44",
                     k, validW[k], doutW[k]);
          end
        end
      end
    end
  endtask

  task automatic test_rdw();
    op_t         ops [$];
    logic [31:0] wantSame [2];
    wantSame[0] = 32'hAAAAAAAA;
    wantSame[1] = 32'h55555555;
    ops.push_back(mk_op(1'b1, 9'd7, 32'hAAAAAAAA, 4'hF, 1'b0, 9'd0));
    ops.push_back(mk_op(1'b1, 9'd7, 32'h55555555, 4'hF, 1'b1, 9'd7));
    ops.push_back(mk_op(1'b0, 9'd0, 32'h0, 4'h0, 1'b1, 9'd7));
    for (int i = 0; i < LAT; i++) ops.push_back(mk_idle());
    for (int i = 0; i < ops.size(); i++) begin
      apply_op(ops[i]);
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({busyW[k], validW[k], doutW[k]} !== {busyLeft[k] > 0, expV[k], expD[k]}) begin
          bad++;
          $display("[TB] FAIL rdw_model dut%0d step %0d got %b/%b/%h want %b/%b/%h", k, i,
                   busyW[k], validW[k], doutW[k], busyLeft[k] > 0, expV[k], expD[k]);
        end
        if (i == LAT) begin
          total++;
          if ({validW[k], doutW[k]} !== {1'b1, wantSame[k]}) begin
            bad++;
            $display("[TB] FAIL rdw_same_cycle dut%0d got %b/%h want 1/%h",
                     k, validW[k], doutW[k], wantSame[k]);
          end
        end
        if (i == LAT + 1) begin
          total++;
          if ({validW[k], doutW[k]} !== {1'b1, 32'h55555555}) begin
            bad++;
            $display("[TB] FAIL rdw_next_read dut%0d got %b/%h want 1/55555555",
                     k, validW[k], doutW[k]);
          end
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    op_t         ops [$];
    logic [31:0] want400 [2];
    want400[0] = 32'h12345678;
    want400[1] = 32'h0;
    ops.push_back(mk_op(1'b1, 9'd400, 32'h12345678, 4'hF, 1'b0, 9'd0));
    ops.push_back(mk_op(1'b0, 9'd0, 32'h0, 4'h0, 1'b1, 9'd400));
    ops.push_back(mk_op(1'b1, 9'd5, 32'hFFFFFFFF, 4'h0, 1'b0, 9'd0));
    ops.push_back(mk_op(1'b0, 9'd0, 32'h0, 4'h0, 1'b1, 9'd5));
    for (int i = 0; i < LAT; i++) ops.push_back(mk_idle());
    for (int i = 0; i < ops.size(); i++) begin
      apply_op(ops[i]);
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({busyW[k], validW[k], doutW[k]} !== {busyLeft[k] > 0, expV[k], expD[k]}) begin
          bad++;
          $display("[TB] FAIL range_model dut%0d step %0d got %b/%b/%h want %b/%b/%h", k, i,
                   busyW[k], validW[k], doutW[k], busyLeft[k] > 0, expV[k], expD[k]);
        end
        if (i == LAT) begin
          total++;
          if ({validW[k], doutW[k]} !== {1'b1, want400[k]}) begin
            bad++;
            $display("[TB] FAIL addr400_read dut%0d got %b/%h want 1/%h",
                     k, validW[k], doutW[k], want400[k]);
          end
        end
        if (i == LAT + 2) begin
          total++;
          if ({validW[k], doutW[k]} !== {1'b1, 32'hDE22BE44}) begin
            bad++;
            $display("[TB] FAIL zero_byte_en dut%0d got %b/%h want 1/de22be44",
                     k, validW[k], doutW[k]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      apply_op(mk_random(c % 2 == 0));
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({busyW[k], validW[k], doutW[k]} !== {busyLeft[k] > 0, expV[k], expD[k]}) begin
          bad++;
          $display("[TB] FAIL random dut%0d cycle %0d got %b/%b/%h want %b/%b/%h", k, c,
                   busyW[k], validW[k], doutW[k], busyLeft[k] > 0, expV[k], expD[k]);
        end
      end
    end
    apply_op(mk_idle());
  endtask

  task automatic test_back_to_back();
    op_t ops [$];
    for (int j = 0; j < 10; j++) ops.push_back(mk_op(1'b1, 9'(j), bb_data(j), 4'hF, 1'b0, 9'd0));
    for (int j = 0; j < 10; j++) ops.push_back(mk_op(1'b0, 9'd0, 32'h0, 4'h0, 1'b1, 9'(j)));
    for (int i = 0; i < LAT; i++) ops.push_back(mk_idle());
    for (int i = 0; i < ops.size(); i++) begin
      apply_op(ops[i]);
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({busyW[k], validW[k], doutW[k]} !== {busyLeft[k] > 0, expV[k], expD[k]}) begin
          bad++;
          $display("[TB] FAIL b2b_model dut%0d step %0d got %b/%b/%h want %b/%b/%h", k, i,
                   busyW[k], validW[k], doutW[k], busyLeft[k] > 0, expV[k], expD[k]);
        end
        if (i >= 9 + LAT && i < 19 + LAT) begin
          total++;
          if ({validW[k], doutW[k]} !== {1'b1, bb_data(i - 9 - LAT)}) begin
            bad++;
            $display("[TB] FAIL b2b_data dut%0d step %0d got %b/%h want 1/%h",
                     k, i, validW[k], doutW[k], bb_data(i - 9 - LAT));
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int  highCnt [2];
    op_t ops [$];
    for (int i = 0; i < 6; i++) begin
      apply_op(mk_op(1'b0, 9'd0, 32'h0, 4'h0, 1'b1, 9'(i)));
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({busyW[k], validW[k], doutW[k]} !== {busyLeft[k] > 0, expV[k], expD[k]}) begin
          bad++;
          $display("[TB] FAIL burst_model dut%0d step %0d got %b/%b/%h want %b/%b/%h", k, i,
                   busyW[k], validW[k], doutW[k], busyLeft[k] > 0, expV[k], expD[k]);
        end
      end
    end
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({busyW[k], validW[k], doutW[k]} !== {1'b1, 1'b0, 32'h0}) begin
        bad++;
        $display("[TB] FAIL async_reset dut%0d got busy/valid/dout=%b/%b/%h want 1/0/00000000",
                 k, busyW[k], validW[k], doutW[k]);
      end
    end
    apply_op(mk_idle());
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 2; k++) highCnt[k] = int'(busyW[k]);
    for (int c = 0; c < DEPTH_A + 2; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        highCnt[k] += int'(busyW[k]);
        total++;
        if ({busyW[k], validW[k], doutW[k]} !== {busyLeft[k] > 0, expV[k], expD[k]}) begin
          bad++;
          $display("[TB] FAIL resweep dut%0d cycle %0d got %b/%b/%h want %b/%b/%h", k, c,
                   busyW[k], validW[k], doutW[k], busyLeft[k] > 0, expV[k], expD[k]);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      total++;
      if (highCnt[k] != depthOf[k]) begin
        bad++;
        $display("[TB] FAIL resweep_busy dut%0d got %0d want %0d", k, highCnt[k], depthOf[k]);
      end
    end
    ops.push_back(mk_op(1'b0, 9'd0, 32'h0, 4'h0, 1'b1, 9'd3));
    for (int i = 0; i < LAT; i++) ops.push_back(mk_idle());
    for (int i = 0; i < ops.size(); i++) begin
      apply_op(ops[i]);
      step();
      for (int k = 0; k < 2; k++) begin
        if (i == LAT - 1) begin
          total++;
          if ({validW[k], doutW[k]} !== {1'b1, 32'h0}) begin
            bad++;
            $display("[TB] FAIL addr3_cleared dut%0d got %b/%h want 1/00000000",
                     k, validW[k], doutW[k]);
          end
        end
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_byte_enable();
    test_rdw();
    test_out_of_range();
    test_random();
    test_back_to_back();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
